btn_debounce: RTL and testbench

Multi-button input conditioner for the board push-buttons. It synchronises the raw pins, debounces them on a shared millisecond tick, and produces clean levels plus single-cycle press, release, long-press and auto-repeat events. It sits between the board input pins and the LED/pattern control logic, which consumes the event pulses as its step and mode controls.

---
 rtl/btn_debounce.sv | 223 ++++++++++++++++++++++
 tb/tb_btn_debounce.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Multi-button input conditioner. Each raw pin is synchronised with a two-flop
// chain, then debounced by its own FSM that only samples on a shared slow tick.
// The FSMs emit clean levels plus one-cycle press, release, long-press and
// auto-repeat pulses for the downstream LED/pattern control logic.
//
// Parameters
//   N_BTN      number of independent buttons
//   TICK_DIV   clk cycles per debounce tick (>= 2)
//   DEBOUNCE_T consecutive stable ticks needed to accept a level change (>= 1)
//   LONG_T     ticks held after an accepted press before btn_long (> DEBOUNCE_T)
//   REPEAT_T   ticks between btn_repeat pulses after btn_long (>= 1)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high; clears all state
//   btn_in       raw button pins, active-high, asynchronous to clk
//   btn_level    debounced button level
//   btn_press    one-cycle pulse when a press is accepted
//   btn_release  one-cycle pulse when a release is accepted
//   btn_long     one-cycle pulse when a held press reaches LONG_T ticks
//   btn_repeat   one-cycle pulse every REPEAT_T ticks after btn_long
//
// Per-button FSM
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | accepted level 0, waiting for the synchronised pin to rise
//   PRESS_DB   | pin high, counting stable ticks before accepting the press
//   HELD       | accepted level 1, counting ticks towards the long press
//   LONG_HELD  | long press reported, counting ticks between repeats
//   RELEASE_DB | pin low, counting stable ticks before accepting the release
// -----------------------------------------------------------------------------

module btn_debounce #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 100000,
    parameter int DEBOUNCE_T = 20,
    parameter int LONG_T     = 1000,
    parameter int REPEAT_T   = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int HOLD_MAX = (LONG_T > REPEAT_T) ? LONG_T : REPEAT_T;
    localparam int DB_W     = $clog2(DEBOUNCE_T + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int TICK_W   = $clog2(TICK_DIV);

    // Counters compare against "last value before the target" so that the
    // increment-and-compare happens without widening the counter.
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_T - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_T - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_T - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    // -------------------------------------------------------------------------
    // Shared tick generator
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Per-button debounce / hold FSMs
    // -------------------------------------------------------------------------
    state_t           state    [N_BTN];
    logic [DB_W-1:0]  db_cnt   [N_BTN];
    logic [HOLD_W-1:0] hold_cnt [N_BTN];
    // Remembers which held state a release debounce was entered from, so a
    // bounce back to 1 resumes the correct hold phase.
    logic [N_BTN-1:0] from_long;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i]    <= IDLE;
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
            from_long   <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_repeat  <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_repeat  <= '0;

            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    IDLE: begin
                        if (sync_q2[i]) begin
                            state[i]  <= PRESS_DB;
                            db_cnt[i] <= '0;
                        end
                    end

                    PRESS_DB: begin
                        if (!sync_q2[i]) begin
                            state[i]  <= IDLE;
                            db_cnt[i] <= '0;
                        end else if (tick) begin
                            if (db_cnt[i] == DB_LAST) begin
                                state[i]     <= HELD;
                                db_cnt[i]    <= '0;
                                hold_cnt[i]  <= '0;
                                btn_level[i] <= 1'b1;
                                btn_press[i] <= 1'b1;
                            end else begin
                                db_cnt[i] <= db_cnt[i] + DB_W'(1);
                            end
                        end
                    end

                    HELD: begin
                        // A falling pin takes priority over a coincident tick;
                        // the hold count is frozen while the release settles.
                        if (!sync_q2[i]) begin
                            state[i]     <= RELEASE_DB;
                            db_cnt[i]    <= '0;
                            from_long[i] <= 1'b0;
                        end else if (tick) begin
                            if (hold_cnt[i] == LONG_LAST) begin
                                state[i]    <= LONG_HELD;
                                hold_cnt[i] <= '0;
                                btn_long[i] <= 1'b1;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                            end
                        end
                    end

                    LONG_HELD: begin
                        if (!sync_q2[i]) begin
                            state[i]     <= RELEASE_DB;
                            db_cnt[i]    <= '0;
                            from_long[i] <= 1'b1;
                        end else if (tick) begin
                            if (hold_cnt[i] == REPEAT_LAST) begin
                                hold_cnt[i]   <= '0;
                                btn_repeat[i] <= 1'b1;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                            end
                        end
                    end

                    RELEASE_DB: begin
                        if (sync_q2[i]) begin
                            state[i]  <= from_long[i] ? LONG_HELD : HELD;
                            db_cnt[i] <= '0;
                        end else if (tick) begin
                            if (db_cnt[i] == DB_LAST) begin
                                state[i]       <= IDLE;
                                db_cnt[i]      <= '0;
                                hold_cnt[i]    <= '0;
                                btn_level[i]   <= 1'b0;
                                btn_release[i] <= 1'b1;
                            end else begin
                                db_cnt[i] <= db_cnt[i] + DB_W'(1);
                            end
                        end
                    end

                    default: begin
                        state[i]     <= IDLE;
                        db_cnt[i]    <= '0;
                        hold_cnt[i]  <= '0;
                        btn_level[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed bench for btn_debounce with TICK_DIV=4, DEBOUNCE_T=3, LONG_T=10,
// REPEAT_T=4. "cyc" counts rising clk edges since the last reset release;
// the FSMs see a tick on every edge where cyc is a multiple of 4. An input
// changed just after edge p is seen by the FSM at edge p+3. Expected pulse
// edges below are derived from those two rules.
// -----------------------------------------------------------------------------

module tb_btn_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;
    logic [3:0] btn_repeat;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int press_cnt   [4] = '{default: 0};
    int release_cnt [4] = '{default: 0};
    int long_cnt    [4] = '{default: 0};
    int repeat_cnt  [4] = '{default: 0};

    btn_debounce #(
        .N_BTN      (4),
        .TICK_DIV   (4),
        .DEBOUNCE_T (3),
        .LONG_T     (10),
        .REPEAT_T   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_repeat  (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (btn_press[i])   press_cnt[i]   <= press_cnt[i] + 1;
            if (btn_release[i]) release_cnt[i] <= release_cnt[i] + 1;
            if (btn_long[i])    long_cnt[i]    <= long_cnt[i] + 1;
            if (btn_repeat[i])  repeat_cnt[i]  <= repeat_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after rising edge number "target".
    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   32'(btn_level),   'h0);
        chk({tag, "_press"},   32'(btn_press),   'h0);
        chk({tag, "_release"}, 32'(btn_release), 'h0);
        chk({tag, "_long"},    32'(btn_long),    'h0);
        chk({tag, "_repeat"},  32'(btn_repeat),  'h0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        cyc   = 0;

        // ---- single press / release on bit 0 ----
        btn_in[0] = 1'b1;                 // seen at 3, ticks 4,8,12
        tick_to(11);
        chk("t1_press_early", 32'(btn_press), 'h0);
        chk("t1_level_early", 32'(btn_level), 'h0);
        tick_to(12);
        chk("t1_press", 32'(btn_press), 'h1);
        chk("t1_level", 32'(btn_level), 'h1);
        tick_to(13);
        chk("t1_press_width", 32'(btn_press), 'h0);
        tick_to(14);
        btn_in[0] = 1'b0;                 // seen at 17, ticks 20,24,28
        tick_to(27);
        chk("t1_level_hold", 32'(btn_level), 'h1);
        chk("t1_release_early", 32'(btn_release), 'h0);
        tick_to(28);
        chk("t1_release", 32'(btn_release), 'h1);
        chk("t1_level_low", 32'(btn_level), 'h0);

        // ---- bounce on bit 1: toggles every 5 clk for 60 clk ----
        for (int k = 0; k < 12; k++) begin
            tick_to(32 + 5 * k);
            btn_in[1] = ((k % 2) == 0);
        end
        tick_to(92);
        btn_in[1] = 1'b1;                 // seen at 95, ticks 96,100,104
        tick_to(103);
        chk("t2_press_early", 32'(btn_press), 'h0);
        chk("t2_bounce_press_cnt", 32'(press_cnt[1]), 'h0);
        tick_to(104);
        chk("t2_press", 32'(btn_press), 'h2);
        chk("t2_level", 32'(btn_level), 'h2);
        tick_to(106);
        chk("t2_press_cnt", 32'(press_cnt[1]), 'h1);
        chk("t2_release_cnt", 32'(release_cnt[1]), 'h0);
        btn_in[1] = 1'b0;                 // seen at 109, ticks 112,116,120
        tick_to(120);
        chk("t2_release", 32'(btn_release), 'h2);

        // ---- long press and auto-repeat on bit 2 ----
        tick_to(124);
        btn_in[2] = 1'b1;                 // seen at 127, press at 136
        tick_to(136);
        chk("t3_press", 32'(btn_press), 'h4);
        tick_to(175);
        chk("t3_long_early", 32'(btn_long), 'h0);
        tick_to(176);                     // 10 ticks after press
        chk("t3_long", 32'(btn_long), 'h4);
        chk("t3_long_level", 32'(btn_level), 'h4);
        tick_to(192);
        chk("t3_repeat1", 32'(btn_repeat), 'h4);
        tick_to(208);
        chk("t3_repeat2", 32'(btn_repeat), 'h4);
        tick_to(224);
        chk("t3_repeat3", 32'(btn_repeat), 'h4);
        tick_to(240);
        chk("t3_repeat4", 32'(btn_repeat), 'h4);

        // 1-tick drop: seen low at 245..248; the hold count is frozen while the
        // release debounces, so the tick at 248 is lost and the next repeat
        // moves from 256 to 260.
        tick_to(242);
        btn_in[2] = 1'b0;
        tick_to(246);
        btn_in[2] = 1'b1;
        tick_to(250);
        chk("t4_level_kept", 32'(btn_level), 'h4);
        chk("t4_no_release", 32'(release_cnt[2]), 'h0);
        tick_to(256);
        chk("t4_repeat_shifted_off", 32'(btn_repeat), 'h0);
        tick_to(260);
        chk("t4_repeat5", 32'(btn_repeat), 'h4);
        tick_to(276);
        chk("t4_repeat6", 32'(btn_repeat), 'h4);
        tick_to(278);
        btn_in[2] = 1'b0;                 // seen at 281, ticks 284,288,292
        tick_to(292);
        chk("t3_release", 32'(btn_release), 'h4);
        chk("t3_release_level", 32'(btn_level), 'h0);
        chk("t3_repeat_cnt", 32'(repeat_cnt[2]), 'h6);
        chk("t3_long_cnt", 32'(long_cnt[2]), 'h1);

        // ---- simultaneous press on bits 0 and 3 ----
        tick_to(296);
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;                 // seen at 299, press at 308
        tick_to(308);
        chk("t5_press_both", 32'(btn_press), 'h9);
        chk("t5_level_both", 32'(btn_level), 'h9);
        tick_to(310);
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;                 // seen at 313, release at 324
        tick_to(324);
        chk("t5_release_both", 32'(btn_release), 'h9);

        // ---- async reset mid-repeat on bit 2 ----
        tick_to(328);
        btn_in[2] = 1'b1;                 // press 340, long 380, repeat 396
        tick_to(340);
        chk("t6_press", 32'(btn_press), 'h4);
        tick_to(380);
        chk("t6_long", 32'(btn_long), 'h4);
        tick_to(396);
        chk("t6_repeat", 32'(btn_repeat), 'h4);
        tick_to(398);
        chk("t6_level_pre", 32'(btn_level), 'h4);
        reset = 1'b1;
        #1;
        chk_all_zero("t6_async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("t6_in_reset");
        reset = 1'b0;
        cyc   = 0;                        // button still held: press at 12
        tick_to(11);
        chk("t6_fresh_press_early", 32'(btn_press), 'h0);
        tick_to(12);
        chk("t6_fresh_press", 32'(btn_press), 'h4);
        chk("t6_fresh_level", 32'(btn_level), 'h4);
        tick_to(20);

        // ---- event totals over the whole run ----
        chk("tot_press0",   32'(press_cnt[0]),   'h2);
        chk("tot_press1",   32'(press_cnt[1]),   'h1);
        chk("tot_press2",   32'(press_cnt[2]),   'h3);
        chk("tot_press3",   32'(press_cnt[3]),   'h1);
        chk("tot_release0", 32'(release_cnt[0]), 'h2);
        chk("tot_release1", 32'(release_cnt[1]), 'h1);
        chk("tot_release2", 32'(release_cnt[2]), 'h1);
        chk("tot_release3", 32'(release_cnt[3]), 'h1);
        chk("tot_long0",    32'(long_cnt[0]),    'h0);
        chk("tot_long2",    32'(long_cnt[2]),    'h2);
        chk("tot_repeat2",  32'(repeat_cnt[2]),  'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
